// File: rtl/cache_fill_fsm_pkg.sv
// Shared types and sizing for the cache miss fill controller.
// Block geometry, state encoding and the block-base helper live here.
package cache_fill_fsm_pkg;

  localparam int WORDS_PER_BLOCK = 8;
  localparam int ADDR_WIDTH      = 16;
  localparam int DATA_WIDTH      = 16;
  localparam int MEM_LATENCY     = 4;
  localparam int WORD_IDX_W      = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W           = WORD_IDX_W + 1;

  localparam logic [ADDR_WIDTH-1:0] BLOCK_OFFSET_MASK = 16'hFFF0;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  function automatic logic [ADDR_WIDTH-1:0] block_base(input logic [ADDR_WIDTH-1:0] addr);
    return addr & BLOCK_OFFSET_MASK;
  endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Bundle of miss, memory-read and cache-array write signals around the fill FSM.
// master = the fill controller, slave = cache plus memory side.
interface cache_fill_fsm_if;
  import cache_fill_fsm_pkg::*;

  logic                  miss_detected;
  logic [ADDR_WIDTH-1:0] miss_address;
  logic                  memory_data_valid;
  logic [DATA_WIDTH-1:0] memory_data;
  logic                  fsm_busy;
  logic                  memory_enable;
  logic [ADDR_WIDTH-1:0] memory_address;
  logic                  write_data_array;
  logic [WORD_IDX_W-1:0] data_array_word;
  logic [DATA_WIDTH-1:0] data_array_data;
  logic                  write_tag_array;

  modport master (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, memory_enable, memory_address,
           write_data_array, data_array_word, data_array_data, write_tag_array
  );

  modport slave (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, memory_enable, memory_address,
           write_data_array, data_array_word, data_array_data, write_tag_array
  );

endinterface

// File: rtl/cache_fill_fsm_word_counter.sv
// Word counter for the fill controller: clear wins over increment, saturates at one block.
// Registered output, updates one cycle after clr/inc.
module word_counter
  import cache_fill_fsm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                                           cnt_d = '0;
    else if (inc && (cnt_q < CNT_W'(WORDS_PER_BLOCK))) cnt_d = cnt_q + CNT_W'(1);
  end

  dff #(.W(CNT_W)) u_cnt_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cnt_d),
    .q     (cnt_q)
  );

  assign cnt = cnt_q;

endmodule

// File: rtl/dff.sv
// Generic register cell with asynchronous active-low clear.
// One cycle d-to-q; no enable, callers hold value by feeding q back.
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill: issues one block of word reads, streams returns into the data array, then writes tag.
// Requests are issued back to back; progress on the data side follows memory_data_valid only.
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  cache_fill_fsm_if.master bus
);

  fill_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CNT_W-1:0]      issue_cnt;
  logic [CNT_W-1:0]      recv_cnt;
  logic                  cnt_clr;
  logic                  issue_inc;
  logic                  recv_inc;
  logic                  issue_open;
  logic                  recv_open;
  logic [ADDR_WIDTH-1:0] issue_off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

  assign issue_open = issue_cnt < CNT_W'(WORDS_PER_BLOCK);
  assign recv_open  = recv_cnt  < CNT_W'(WORDS_PER_BLOCK);
  // Word index to byte offset: words are two bytes wide.
  assign issue_off  = {{(ADDR_WIDTH-CNT_W-1){1'b0}}, issue_cnt, 1'b0};

  always_comb begin
    state_d              = state_q;
    base_d               = base_q;
    cnt_clr              = 1'b0;
    issue_inc            = 1'b0;
    recv_inc             = 1'b0;
    bus.fsm_busy         = 1'b0;
    bus.memory_enable    = 1'b0;
    bus.memory_address   = '0;
    bus.write_data_array = 1'b0;
    bus.data_array_word  = '0;
    bus.data_array_data  = '0;
    bus.write_tag_array  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.miss_detected) begin
          base_d  = block_base(bus.miss_address);
          cnt_clr = 1'b1;
          state_d = FILL;
        end
      end

      FILL: begin
        bus.fsm_busy       = 1'b1;
        bus.memory_enable  = issue_open;
        bus.memory_address = base_q + issue_off;
        issue_inc          = issue_open;
        // A return after the block is complete cannot happen; drop it if it does.
        if (bus.memory_data_valid && recv_open) begin
          bus.write_data_array = 1'b1;
          bus.data_array_word  = recv_cnt[WORD_IDX_W-1:0];
          bus.data_array_data  = bus.memory_data;
          recv_inc             = 1'b1;
          if (recv_cnt == CNT_W'(WORDS_PER_BLOCK - 1)) begin
            bus.write_tag_array = 1'b1;
            state_d             = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  word_counter u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (issue_inc),
    .cnt   (issue_cnt)
  );

  word_counter u_recv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (recv_inc),
    .cnt   (recv_cnt)
  );

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: pipelined memory model plus per-cycle expectations from block timing rules.
module tb_cache_fill_fsm;
  import cache_fill_fsm_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  cache_fill_fsm_if bus ();

  cache_fill_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          due;
    logic [15:0] addr;
  } req_t;

  req_t req_q[$];
  int   cyc       = 0;
  int   mem_gap   = 0;
  bit   mem_noise = 1'b0;
  int   last_dlv  = -1000;

  // Memory: each request sampled in cycle c returns addr^A5A5 no earlier than c+latency,
  // with at least mem_gap idle cycles between returns.
  initial begin : mem_model
    req_t r;
    bus.memory_data_valid = 1'b0;
    bus.memory_data       = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      bus.memory_data_valid = 1'b0;
      bus.memory_data       = '0;
      if (!rst_n) begin
        req_q.delete();
      end else if (req_q.size() > 0 && req_q[0].due <= cyc && (cyc - last_dlv) > mem_gap) begin
        r = req_q.pop_front();
        bus.memory_data_valid = 1'b1;
        bus.memory_data       = r.addr ^ 16'hA5A5;
        last_dlv              = cyc;
      end else if (mem_noise) begin
        bus.memory_data_valid = 1'($urandom_range(0, 1));
        bus.memory_data       = 16'($urandom);
      end
      @(negedge clk);
      if (rst_n && bus.memory_enable) begin
        r.due  = cyc + MEM_LATENCY;
        r.addr = bus.memory_address;
        req_q.push_back(r);
      end
    end
  end

  function automatic logic [38:0] all_outs();
    return {bus.fsm_busy, bus.memory_enable, bus.memory_address, bus.write_data_array,
            bus.data_array_word, bus.data_array_data, bus.write_tag_array};
  endfunction

  // Runs one fill and checks every output in each cycle of it plus the first idle cycle after.
  task automatic do_fill(input string name, input logic [15:0] addr, input int gap,
                         input bit hold, input logic [15:0] next_addr, input bit chained);
    logic [15:0] base, e_addr, e_data;
    logic [2:0]  e_word;
    logic        e_busy, e_en, e_wr, e_tag;
    int          last, idx;
    base    = {addr[15:4], 4'h0};
    mem_gap = gap;
    last    = MEM_LATENCY + (WORDS_PER_BLOCK - 1) * (gap + 1);
    if (!chained) begin
      @(posedge clk); #1;
      bus.miss_detected = 1'b1;
      bus.miss_address  = addr;
    end
    @(posedge clk); #1;
    if (!hold) begin
      bus.miss_detected = 1'b0;
      bus.miss_address  = 16'($urandom);
    end
    for (int k = 0; k <= last + 1; k++) begin
      @(negedge clk);
      e_busy = (k <= last);
      e_en   = (k < WORDS_PER_BLOCK);
      e_wr   = (k >= MEM_LATENCY) && (k <= last) && (((k - MEM_LATENCY) % (gap + 1)) == 0);
      idx    = e_wr ? (k - MEM_LATENCY) / (gap + 1) : 0;
      e_word = 3'(idx);
      e_addr = (k <= last) ? base + 16'(2 * k) : 16'h0;
      e_data = e_wr ? ((base + 16'(2 * idx)) ^ 16'hA5A5) : 16'h0;
      e_tag  = (k == last);
      n_checks++;
      if (bus.fsm_busy !== e_busy) begin
        n_fail++;
        $display("FAIL %s busy cycle %0d: got %b want %b", name, k, bus.fsm_busy, e_busy);
      end
      n_checks++;
      if (bus.memory_enable !== e_en) begin
        n_fail++;
        $display("FAIL %s mem_en cycle %0d: got %b want %b", name, k, bus.memory_enable, e_en);
      end
      if (e_en || k > last) begin
        n_checks++;
        if (bus.memory_address !== e_addr) begin
          n_fail++;
          $display("FAIL %s mem_addr cycle %0d: got %h want %h", name, k, bus.memory_address, e_addr);
        end
      end
      n_checks++;
      if (bus.write_data_array !== e_wr) begin
        n_fail++;
        $display("FAIL %s wr_data cycle %0d: got %b want %b", name, k, bus.write_data_array, e_wr);
      end
      n_checks++;
      if (bus.data_array_word !== e_word || bus.data_array_data !== e_data) begin
        n_fail++;
        $display("FAIL %s word/data cycle %0d: got %0d/%h want %0d/%h", name, k,
                 bus.data_array_word, bus.data_array_data, e_word, e_data);
      end
      n_checks++;
      if (bus.write_tag_array !== e_tag) begin
        n_fail++;
        $display("FAIL %s wr_tag cycle %0d: got %b want %b", name, k, bus.write_tag_array, e_tag);
      end
      if (k <= last) begin
        @(posedge clk); #1;
        if (hold && k == last) bus.miss_address = next_addr;
      end
    end
  endtask

  task automatic test_reset();
    bus.miss_detected = 1'b0;
    bus.miss_address  = 16'h0;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (all_outs() !== 39'h0) begin
      n_fail++;
      $display("FAIL reset_outs: got %h want 0", all_outs());
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mem_noise = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.miss_address = 16'($urandom);
      @(negedge clk);
      n_checks++;
      if (all_outs() !== 39'h0) begin
        n_fail++;
        $display("FAIL idle_outs cycle %0d: got %h want 0", i, all_outs());
      end
      @(posedge clk); #1;
    end
    mem_noise = 1'b0;
  endtask

  task automatic test_basic_fill();
    do_fill("basic", 16'h1236, 0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_wrap();
    do_fill("wrap", 16'hFFFE, 0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_fill("held_first", 16'h2228, 0, 1'b1, 16'h0040, 1'b0);
    do_fill("held_second", 16'h0040, 0, 1'b0, 16'h0, 1'b1);
  endtask

  task automatic test_reset_mid_fill();
    mem_gap = 0;
    @(posedge clk); #1;
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'h3456;
    @(posedge clk); #1;
    bus.miss_detected = 1'b0;
    for (int k = 0; k < 6; k++) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.write_data_array !== 1'b1 || bus.data_array_word !== 3'd2) begin
      n_fail++;
      $display("FAIL midrst_third_write: got wr=%b word=%0d want wr=1 word=2",
               bus.write_data_array, bus.data_array_word);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (all_outs() !== 39'h0) begin
      n_fail++;
      $display("FAIL midrst_immediate: got %h want 0", all_outs());
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (all_outs() !== 39'h0) begin
        n_fail++;
        $display("FAIL midrst_held cycle %0d: got %h want 0", i, all_outs());
      end
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.write_tag_array !== 1'b0 || bus.write_data_array !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_after cycle %0d: got tag=%b wr=%b want 0 0", i,
                 bus.write_tag_array, bus.write_data_array);
      end
    end
    do_fill("post_reset", 16'h0100, 0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_stretched();
    do_fill("stretched", 16'h5A5E, 2, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      do_fill("random", 16'($urandom), int'($urandom_range(0, 2)), 1'b0, 16'h0, 1'b0);
      repeat (int'($urandom_range(0, 3))) @(posedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_wrap();
    test_back_to_back();
    test_reset_mid_fill();
    test_stretched();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling controller between the CPU's cache and the multi-cycle main memory. It replaces the single-cycle memory port the CPU used in phase 1.
- On a cache miss it fetches the full 8-word (16-byte) block from a pipelined 4-cycle-latency memory and streams each word into the cache data array.
- It then writes the tag/valid entry.
- While it runs, it holds the CPU stalled through fsm_busy.

Parameters:
- WORDS_PER_BLOCK, 8, number of 16-bit words fetched per miss. Must be a power of 2, at most 8.
- ADDR_WIDTH, 16, byte address width.
- MEM_LATENCY, 4, memory read latency in cycles. Informational only: the FSM is driven by memory_data_valid, not by counting latency.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- miss_detected  in  1  cache lookup missed this cycle
- miss_address  in  16  byte address that missed
- memory_data_valid  in  1  memory_data holds a returned word this cycle
- memory_data  in  16  read data from memory
- fsm_busy  out  1  fill in progress; CPU must stall
- memory_enable  out  1  read request to memory this cycle
- memory_address  out  16  request byte address
- write_data_array  out  1  write data_array_data into the cache block at data_array_word
- data_array_word  out  3  word index within the block being written
- data_array_data  out  16  word to write (equals memory_data)
- write_tag_array  out  1  write tag and valid for the latched block

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low; clock port clk, reset port rst_n.
- Reset values:
  - state IDLE, all counters 0, base address 0.
  - All outputs 0.
  - Reset asserted mid-fill aborts immediately: no further tag or data writes occur.
- States are IDLE and FILL; the state is held in a register.
- IDLE:
  - fsm_busy=0, memory_enable=0, memory_address=0, write_*=0.
  - miss_detected=1 at a rising edge latches base = miss_address with the low 4 bits cleared, clears issue_cnt and recv_cnt, and enters FILL.
  - memory_data_valid is ignored in IDLE.
- FILL:
  - fsm_busy=1.
  - Request side: memory_enable=(issue_cnt<8) and memory_address=base+(issue_cnt<<1), both combinational. issue_cnt increments each cycle while below 8, then saturates at 8.
  - Data side: when memory_data_valid=1, write_data_array=1, data_array_word=recv_cnt[2:0], data_array_data=memory_data, and recv_cnt increments.
  - Completion: when memory_data_valid=1 and recv_cnt==7, write_tag_array=1 in the same cycle and the next state is IDLE.
  - miss_detected is ignored in FILL, including on the final cycle. The cache re-presents the miss, which is sampled in IDLE on the following edge.
- Timing with 4-cycle memory (cycle 0 is the first FILL cycle):
  - Requests go out in cycles 0–7.
  - Data returns in cycles 4–11.
  - write_tag_array is asserted in cycle 11.
  - fsm_busy is 1 for exactly 12 cycles.
  - The earliest new fill starts in cycle 13.
- Address arithmetic is mod 2^16. The block base is 16-byte aligned, so the 8 request addresses never carry out of the block.
- A memory_data_valid received after recv_cnt has reached 8 is impossible by protocol; the FSM ignores it and writes nothing.
- data_array_word and data_array_data are 0 whenever write_data_array=0.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=1'b0, FILL=1'b1)
  - WORDS_PER_BLOCK
  - BLOCK_OFFSET_MASK (16'hFFF0)
  - the word-index width
- Sub-module word_counter:
  - 4-bit register built from the codebase dff cells.
  - Inputs: clk, rst_n, clr, inc.
  - Saturates at WORDS_PER_BLOCK.
  - Instantiated twice, for issue_cnt and recv_cnt.
- The FSM, address generation, and output decode live in cache_fill_fsm.

Test Plan:
1. Reset then idle: hold rst_n=0, then release with miss_detected=0 for 5 cycles -> all outputs stay 0 and fsm_busy=0.
2. Basic fill: miss_detected=1 with miss_address=16'h1236, 4-cycle memory model returning addr^16'hA5A5.
   - memory_address sequence is 16'h1230, 1232, …, 123E in cycles 0–7.
   - write_data_array is asserted in cycles 4–11 with data_array_word 0..7 and matching data.
   - write_tag_array is asserted only in cycle 11.
   - fsm_busy is high for exactly 12 cycles.
3. Wrap boundary: miss_address=16'hFFFE -> requests go to FFF0..FFFE with no wrap past FFFE; 8 data writes follow, then the tag write.
4. Miss held high through the fill, then a second miss at 16'h0040:
   - No restart occurs during the first fill.
   - A new fill begins on the cycle after fsm_busy falls, with first request address 16'h0040.
5. Reset mid-fill: assert rst_n=0 in cycle 6 (after 3 data writes) -> outputs go to 0 immediately and write_tag_array never asserts. After release, a new miss at 16'h0100 completes normally.
6. Stretched valid: memory model inserts 2-cycle gaps between valids -> exactly 8 data writes with indices 0..7 in order; write_tag_array coincides with the 8th write.
